rf_param: RTL
=============

RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 Parameter W, default 8: register data width in bits; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 16: number of registers; SHALL be a power of 2 and >= 4. AW = log2(DEPTH).
REQ-003 Parameter FLAG_IDX, default DEPTH-1: index of the overflow flag register; SHALL be in 1..DEPTH-1.
REQ-004 Port clk  in  1: single clock, all state on rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port we  in  1: write enable for the general write port.
REQ-007 Port ptr_w  in  AW: write address; also the store_value read address.
REQ-008 Port di  in  W: write data.
REQ-009 Port ptr_a  in  AW: read address, port A.
REQ-010 Port ptr_b  in  W: read address (low AW bits) or immediate operand, port B.
REQ-011 Port const_flag  in  1: 1 = ptr_b is an immediate.
REQ-012 Port ov_we  in  1: overflow flag update enable.
REQ-013 Port r_overflow  in  1: new overflow flag value.
REQ-014 Port clr_req  in  1: single-cycle request to clear all registers.
REQ-015 Port clr_busy  out  1: high while a clear sweep is in progress.
REQ-016 Port do_a  out  W: read data, port A.
REQ-017 Port do_b  out  W: read data or immediate, port B.
REQ-018 Port store_value  out  W: contents of register ptr_w.

Function
REQ-019 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-020 General write: at a rising edge with we=1, clr_busy=0, ptr_w not 0 and not FLAG_IDX, reg[ptr_w] SHALL take di.
REQ-021 we targeting FLAG_IDX SHALL be discarded; the flag register is written only via ov_we.
REQ-022 Flag write: at a rising edge with ov_we=1 and clr_busy=0, reg[FLAG_IDX] SHALL take {W-1 zeros, r_overflow}.
REQ-023 Reads SHALL be combinational, zero-cycle latency.
REQ-024 do_a: 0 if ptr_a=0; else di if a general write to ptr_a is qualified this cycle (write-through forwarding); else the zero-extended r_overflow if ptr_a=FLAG_IDX and a flag write is qualified this cycle; else reg[ptr_a].
REQ-025 do_b: ptr_b if const_flag=1; otherwise the same rule as REQ-024 applied to ptr_b[AW-1:0].
REQ-026 store_value SHALL equal reg[ptr_w] as stored, without forwarding.
REQ-027 Clear FSM states: IDLE and SWEEP.
REQ-028 In IDLE, clr_req=1 SHALL enter SWEEP at the next edge, with the index counter set to 1. A write qualified in that same cycle SHALL still occur.
REQ-029 In SWEEP, each edge SHALL zero reg[index] and increment index. After zeroing index DEPTH-1, the FSM SHALL return to IDLE. A sweep SHALL take exactly DEPTH-1 cycles.
REQ-030 clr_busy SHALL equal (state == SWEEP).
REQ-031 While in SWEEP: we and ov_we SHALL be ignored; clr_req SHALL be ignored (no restart); reads SHALL return current contents without forwarding.
REQ-032 Index wrap-around SHALL NOT occur; the counter SHALL be AW bits and stop at DEPTH-1.

Reset
REQ-033 rst_n=0 SHALL asynchronously zero all registers including the flag, force IDLE, and zero the index; clr_busy SHALL read 0.
REQ-034 Reset asserted mid-sweep SHALL abort the sweep immediately. Operation SHALL resume in IDLE at the first edge after rst_n rises.

Structure
REQ-035 Shared package rf_pkg SHALL hold the W/DEPTH defaults and the FSM state enum (IDLE, SWEEP).
REQ-036 The clear FSM and counter SHALL be a sub-module rf_clear_seq, outputting clr_busy, a zeroing strobe and the index.
REQ-037 Register storage SHALL be flip-flops with no latches; all read and forward logic SHALL be in rf_param.

Verification (W=8, DEPTH=16, FLAG_IDX=15)
REQ-038 Write then read: we=1, ptr_w=3, di=0x5A -> do_a=0x5A combinationally in the same cycle with ptr_a=3 (forwarding). After the edge, with we=0, do_a=0x5A and store_value=0x5A.
REQ-039 Zero/immediate/flag: write 0x77 to reg 0 -> do_a(ptr_a=0)=0x00. const_flag=1, ptr_b=0xC3 -> do_b=0xC3. we to reg 15 with di=0xFF -> reg 15 unchanged. ov_we=1, r_overflow=1 -> do_b(ptr_b=15)=0x01.
REQ-040 Clear: fill regs 1..15 with nonzero values, pulse clr_req -> clr_busy high for exactly 15 cycles. A we to reg 2 during the sweep is dropped. Afterwards all regs read 0.
REQ-041 Simultaneous: clr_req with we (ptr_w=4, di=0x11) in IDLE -> the write lands, then reg 4 reads 0 after the sweep. A second clr_req mid-sweep does not extend the 15-cycle busy.
REQ-042 Reset mid-sweep: rst_n=0 at sweep cycle 6 -> clr_busy=0 immediately, all regs 0. After release, a write of 0x33 to reg 9 succeeds on the next edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and clear-sequencer state type for the parameterised register file.
package rf_pkg;

  localparam int unsigned RfW     = 8;
  localparam int unsigned RfDepth = 16;

  typedef enum logic {
    StIdle,
    StSweep
  } clr_state_e;

endpackage

// File: rtl/rf_param_if.sv
// Register-file access bus: write port, two read ports, flag update and clear request.
interface rf_param_if
  import rf_pkg::*;
#(
  parameter int unsigned W     = RfW,
  parameter int unsigned DEPTH = RfDepth
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          we;
  logic [AW-1:0] ptr_w;
  logic [W-1:0]  di;
  logic [AW-1:0] ptr_a;
  logic [W-1:0]  ptr_b;
  logic          const_flag;
  logic          ov_we;
  logic          r_overflow;
  logic          clr_req;
  logic          clr_busy;
  logic [W-1:0]  do_a;
  logic [W-1:0]  do_b;
  logic [W-1:0]  store_value;

  modport master (
    output we, ptr_w, di, ptr_a, ptr_b, const_flag, ov_we, r_overflow, clr_req,
    input  clr_busy, do_a, do_b, store_value
  );

  modport slave (
    input  we, ptr_w, di, ptr_a, ptr_b, const_flag, ov_we, r_overflow, clr_req,
    output clr_busy, do_a, do_b, store_value
  );

endinterface

// File: rtl/rf_clear_seq.sv
// Clear sequencer: on request, walks index 1..DEPTH-1 once, strobing a zero per cycle.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = RfDepth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     zero_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StSweep;
          idx_d   = AW'(1);
        end
      end
      StSweep: begin
        // Counter parks at the last index rather than wrapping.
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_busy_o = (state_q == StSweep);
  assign zero_o     = (state_q == StSweep);
  assign idx_o      = idx_q;

endmodule

// File: rtl/rf_param.sv
// Parameterised register file: hardwired-zero reg 0, protected flag register,
// write-through read forwarding, immediate operand on port B and a sequenced clear.
module rf_param
  import rf_pkg::*;
#(
  parameter int unsigned W        = RfW,
  parameter int unsigned DEPTH    = RfDepth,
  parameter int unsigned FLAG_IDX = DEPTH - 1
) (
  input logic       clk,
  input logic       rst_n,
  rf_param_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] FlagAddr = AW'(FLAG_IDX);

  logic [W-1:0]  regs_q [DEPTH];
  logic [W-1:0]  regs_d [DEPTH];
  logic          clr_busy;
  logic          clr_zero;
  logic [AW-1:0] clr_idx;
  logic          gen_we;
  logic          flag_we;
  logic [AW-1:0] ptr_b_addr;

  rf_clear_seq #(
    .DEPTH(DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req_i (bus.clr_req),
    .clr_busy_o(clr_busy),
    .zero_o    (clr_zero),
    .idx_o     (clr_idx)
  );

  assign gen_we  = bus.we && !clr_busy && (bus.ptr_w != '0) && (bus.ptr_w != FlagAddr);
  assign flag_we = bus.ov_we && !clr_busy;

  always_comb begin
    regs_d = regs_q;
    if (clr_zero) begin
      regs_d[clr_idx] = '0;
    end else begin
      if (gen_we) begin
        regs_d[bus.ptr_w] = bus.di;
      end
      if (flag_we) begin
        regs_d[FLAG_IDX] = {{(W-1){1'b0}}, bus.r_overflow};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Pending writes are qualified with !clr_busy, so forwarding is off during a sweep.
  function automatic logic [W-1:0] read_fwd(
    input logic [AW-1:0] p,
    input logic [W-1:0]  stored,
    input logic          wr_en,
    input logic [AW-1:0] wr_addr,
    input logic [W-1:0]  wr_data,
    input logic          fl_en,
    input logic          fl_val
  );
    if (p == '0) begin
      return '0;
    end else if (wr_en && (p == wr_addr)) begin
      return wr_data;
    end else if (fl_en && (p == FlagAddr)) begin
      return {{(W-1){1'b0}}, fl_val};
    end
    return stored;
  endfunction

  assign ptr_b_addr = bus.ptr_b[AW-1:0];

  always_comb begin
    bus.do_a = read_fwd(bus.ptr_a, regs_q[bus.ptr_a], gen_we, bus.ptr_w, bus.di,
                        flag_we, bus.r_overflow);
    if (bus.const_flag) begin
      bus.do_b = bus.ptr_b;
    end else begin
      bus.do_b = read_fwd(ptr_b_addr, regs_q[ptr_b_addr], gen_we, bus.ptr_w, bus.di,
                          flag_we, bus.r_overflow);
    end
  end

  assign bus.store_value = regs_q[bus.ptr_w];
  assign bus.clr_busy    = clr_busy;

endmodule
